// File: rtl/seq_resp_checker.sv
// Checks "cstart -> req, then gnt DELAY cycles later" independently on NCH channels.
// Optional first-fail capture is enabled by defining SEQ_RESP_CHECKER_FIRST_FAIL_EN.
module seq_resp_checker #(
    parameter int NCH   = 4,
    parameter int DELAY = 2,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [NCH-1:0]   cstart,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   gnt,
    output logic [NCH-1:0]   pass,
    output logic [NCH-1:0]   fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
`ifdef SEQ_RESP_CHECKER_FIRST_FAIL_EN
    output logic             busy,
    output logic             ff_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ff_chan,
    output logic [31:0]      ff_time
`else
    output logic             busy
`endif
);

    localparam int PW = $clog2(NCH + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    generate
        if (NCH < 1 || DELAY < 1 || MODE < 0 || MODE > 1) begin : g_bad_params
            $error("seq_resp_checker: illegal parameters (need NCH>=1, DELAY>=1, MODE in {0,1})");
        end
    endgenerate

    logic [NCH-1:0] start;
    logic [NCH-1:0] start_q;
    logic [NCH-1:0] chk;
    logic [NCH-1:0] enter;
    logic [NCH-1:0] pass_d;
    logic [NCH-1:0] fail_d;
    logic [NCH-1:0] stage [DELAY];
    logic           busy_any;
    logic [PW-1:0]  pass_pc;
    logic [PW-1:0]  fail_pc;
    logic [SW-1:0]  pass_sum;
    logic [SW-1:0]  fail_sum;

    assign start = cstart & {NCH{en}};

    // Non-overlapped mode looks at req one cycle after the antecedent.
    generate
        if (MODE == 1) begin : g_nonoverlap
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    start_q <= '0;
                end else begin
                    start_q <= start;
                end
            end
            assign chk = start_q;
        end else begin : g_overlap
            assign start_q = '0;
            assign chk     = start;
        end
    endgenerate

    assign enter  = chk & req;
    assign pass_d = stage[DELAY-1] & gnt;
    assign fail_d = (chk & ~req) | (stage[DELAY-1] & ~gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DELAY; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= enter;
            for (int k = 1; k < DELAY; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= '0;
            fail <= '0;
        end else begin
            pass <= pass_d;
            fail <= fail_d;
        end
    end

    // Built from flops only, so busy never depends on the current inputs.
    always_comb begin
        busy_any = |start_q;
        for (int k = 0; k < DELAY; k++) begin
            busy_any = busy_any | (|stage[k]);
        end
    end

    assign busy = busy_any;

    always_comb begin
        pass_pc = '0;
        fail_pc = '0;
        for (int i = 0; i < NCH; i++) begin
            pass_pc = pass_pc + PW'(pass[i]);
            fail_pc = fail_pc + PW'(fail[i]);
        end
    end

    assign pass_sum = SW'(pass_cnt) + SW'(pass_pc);
    assign fail_sum = SW'(fail_cnt) + SW'(fail_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            pass_cnt <= (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
            fail_cnt <= (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
        end
    end

`ifdef SEQ_RESP_CHECKER_FIRST_FAIL_EN
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [31:0]   cyc;
    logic [CW-1:0] low_idx;

    always_comb begin
        low_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (fail[i]) begin
                low_idx = CW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      <= '0;
            ff_valid <= 1'b0;
            ff_chan  <= '0;
            ff_time  <= '0;
        end else begin
            cyc <= cyc + 32'd1;
            if (clr) begin
                ff_valid <= 1'b0;
                ff_chan  <= '0;
                ff_time  <= '0;
            end else if (!ff_valid && (|fail)) begin
                ff_valid <= 1'b1;
                ff_chan  <= low_idx;
                ff_time  <= cyc;
            end
        end
    end
`endif

endmodule
